// File: rtl/conv_feeder_pkg.sv
// Shared types, default geometry and sizing helpers for the convolution row feeder.
package conv_feeder_pkg;

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } feeder_state_e;

  localparam int unsigned DEF_D  = 4;
  localparam int unsigned DEF_H  = 12;
  localparam int unsigned DEF_W  = 12;
  localparam int unsigned DEF_DW = 8;

  localparam int unsigned SLOTS     = 3;
  localparam int unsigned SLOT_BITS = 2;

  function automatic int unsigned cnt_bits(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int unsigned row_bits(input int unsigned dw, input int unsigned w);
    return dw * (w + 2);
  endfunction

  localparam int unsigned ROW_BITS = row_bits(DEF_DW, DEF_W);
  localparam int unsigned COL_BITS = cnt_bits(DEF_W);
  localparam int unsigned CH_BITS  = cnt_bits(DEF_D);
  localparam int unsigned ROW_CNT_BITS = cnt_bits(DEF_H);

  // Circular slot arithmetic over the three row slots.
  function automatic logic [SLOT_BITS-1:0] slot_inc(input logic [SLOT_BITS-1:0] s);
    return (s == SLOT_BITS'(SLOTS - 1)) ? '0 : s + SLOT_BITS'(1);
  endfunction

  function automatic logic [SLOT_BITS-1:0] slot_dec(input logic [SLOT_BITS-1:0] s);
    return (s == '0) ? SLOT_BITS'(SLOTS - 1) : s - SLOT_BITS'(1);
  endfunction

endpackage

// File: rtl/conv_line_buffer.sv
// Three circular row slots per channel; one pixel write port and three padded row reads
// that forward a same-cycle write so a just-completed row is visible immediately.
module conv_line_buffer
  import conv_feeder_pkg::*;
#(
  parameter int unsigned D  = DEF_D,
  parameter int unsigned W  = DEF_W,
  parameter int unsigned DW = DEF_DW
) (
  input  logic                       clk,
  input  logic                       wr_en,
  input  logic [cnt_bits(D)-1:0]     wr_ch,
  input  logic [SLOT_BITS-1:0]       wr_slot,
  input  logic [cnt_bits(W)-1:0]     wr_col,
  input  logic [DW-1:0]              wr_pix,
  input  logic [cnt_bits(D)-1:0]     rd_ch,
  input  logic [SLOT_BITS-1:0]       rd_slot0,
  input  logic [SLOT_BITS-1:0]       rd_slot1,
  input  logic [SLOT_BITS-1:0]       rd_slot2,
  output logic [row_bits(DW,W)-1:0]  rd_row0_c,
  output logic [row_bits(DW,W)-1:0]  rd_row1_c,
  output logic [row_bits(DW,W)-1:0]  rd_row2_c
);

  localparam int unsigned RW = row_bits(DW, W);
  localparam int unsigned XB = cnt_bits(W);

  logic [DW-1:0]        mem [D][SLOTS][W];
  logic [SLOT_BITS-1:0] slot_sel [SLOTS];
  logic [RW-1:0]        row_c [SLOTS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ch][wr_slot][wr_col] <= wr_pix;
  end

  assign slot_sel[0] = rd_slot0;
  assign slot_sel[1] = rd_slot1;
  assign slot_sel[2] = rd_slot2;

  // Columns 0 and W+1 stay zero; interior columns come from storage or the live write.
  always_comb begin
    for (int p = 0; p < SLOTS; p++) begin
      row_c[p] = '0;
      for (int x = 0; x < W; x++) begin
        if (wr_en && (wr_ch == rd_ch) && (wr_slot == slot_sel[p]) && (wr_col == XB'(x)))
          row_c[p][(x+1)*DW +: DW] = wr_pix;
        else
          row_c[p][(x+1)*DW +: DW] = mem[rd_ch][slot_sel[p]][x];
      end
    end
  end

  assign rd_row0_c = row_c[0];
  assign rd_row1_c = row_c[1];
  assign rd_row2_c = row_c[2];

endmodule

// File: rtl/conv_row_feeder.sv
// Raster-to-window feeder: buffers three rows per channel and issues padded row triples.
// Optional sticky protocol-error detection is built when CONV_FEEDER_ERR_EN is defined.
module conv_row_feeder
  import conv_feeder_pkg::*;
#(
  parameter int unsigned D                = DEF_D,
  parameter int unsigned H                = DEF_H,
  parameter int unsigned W                = DEF_W,
  parameter int unsigned input_DATA_WIDTH = DEF_DW
) (
  input  logic                                 clk,
  input  logic                                 rstn_i,
  input  logic signed [input_DATA_WIDTH-1:0]   pix_i,
  input  logic                                 pix_valid_i,
  output logic                                 pix_ready_o,
  input  logic                                 conv_done_i,
  output logic [input_DATA_WIDTH*(W+2)-1:0]    image0_o,
  output logic [input_DATA_WIDTH*(W+2)-1:0]    image1_o,
  output logic [input_DATA_WIDTH*(W+2)-1:0]    image2_o,
  output logic                                 image_start_o,
  output logic                                 frame_done_o,
  output logic                                 err_o
);

  localparam int unsigned DW = input_DATA_WIDTH;
  localparam int unsigned RW = row_bits(DW, W);
  localparam int unsigned XB = cnt_bits(W);
  localparam int unsigned DB = cnt_bits(D);
  localparam int unsigned YB = cnt_bits(H);

  localparam logic [XB-1:0] X_LAST  = XB'(W - 1);
  localparam logic [DB-1:0] D_LAST  = DB'(D - 1);
  localparam logic [YB-1:0] Y_LAST  = YB'(H - 1);
  localparam logic [YB-1:0] Y_PEN   = YB'(H - 2);

  feeder_state_e        state_q, state_d;
  logic [XB-1:0]        in_x_q, in_x_d;
  logic [DB-1:0]        in_d_q, in_d_d;
  logic [YB-1:0]        in_y_q, in_y_d;
  logic [SLOT_BITS-1:0] wr_slot_q, wr_slot_d;
  logic [YB-1:0]        out_row_q, out_row_d;
  logic [DB-1:0]        out_d_q, out_d_d;
  logic [SLOT_BITS-1:0] mid_q, mid_d;
  logic                 frame_done_d;
  logic                 hs;
  logic [RW-1:0]        rd_row0_c, rd_row1_c, rd_row2_c;
  logic [RW-1:0]        win0_c, win1_c, win2_c;

  conv_line_buffer #(.D(D), .W(W), .DW(DW)) u_line_buffer (
    .clk       (clk),
    .wr_en     (hs),
    .wr_ch     (in_d_q),
    .wr_slot   (wr_slot_q),
    .wr_col    (in_x_q),
    .wr_pix    (pix_i),
    .rd_ch     (out_d_d),
    .rd_slot0  (slot_dec(mid_d)),
    .rd_slot1  (mid_d),
    .rd_slot2  (slot_inc(mid_d)),
    .rd_row0_c (rd_row0_c),
    .rd_row1_c (rd_row1_c),
    .rd_row2_c (rd_row2_c)
  );

  // Top and bottom padding rows are muxed in, never stored.
  assign win0_c = (out_row_d == '0)     ? '0 : rd_row0_c;
  assign win1_c = rd_row1_c;
  assign win2_c = (out_row_d == Y_LAST) ? '0 : rd_row2_c;

  always_comb begin
    state_d      = state_q;
    in_x_d       = in_x_q;
    in_d_d       = in_d_q;
    in_y_d       = in_y_q;
    wr_slot_d    = wr_slot_q;
    out_row_d    = out_row_q;
    out_d_d      = out_d_q;
    mid_d        = mid_q;
    frame_done_d = 1'b0;
    hs           = 1'b0;
    case (state_q)
      ST_FILL: begin
        if (pix_valid_i && pix_ready_o) begin
          hs = 1'b1;
          if (in_x_q == X_LAST) begin
            in_x_d = '0;
            if (in_d_q == D_LAST) begin
              // Input row complete across all channels.
              in_d_d    = '0;
              wr_slot_d = slot_inc(wr_slot_q);
              in_y_d    = (in_y_q == Y_LAST) ? '0 : in_y_q + YB'(1);
              if (in_y_q != '0) state_d = ST_ISSUE;
            end else begin
              in_d_d = in_d_q + DB'(1);
            end
          end else begin
            in_x_d = in_x_q + XB'(1);
          end
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (conv_done_i) begin
          if (out_d_q != D_LAST) begin
            out_d_d = out_d_q + DB'(1);
            state_d = ST_ISSUE;
          end else if (out_row_q == Y_PEN) begin
            // Bottom row needs no further input.
            out_d_d   = '0;
            out_row_d = out_row_q + YB'(1);
            mid_d     = slot_inc(mid_q);
            state_d   = ST_ISSUE;
          end else if (out_row_q == Y_LAST) begin
            frame_done_d = 1'b1;
            in_x_d       = '0;
            in_d_d       = '0;
            in_y_d       = '0;
            wr_slot_d    = '0;
            out_row_d    = '0;
            out_d_d      = '0;
            mid_d        = '0;
            state_d      = ST_FILL;
          end else begin
            out_d_d   = '0;
            out_row_d = out_row_q + YB'(1);
            mid_d     = slot_inc(mid_q);
            state_d   = ST_FILL;
          end
        end
      end
      default: state_d = ST_FILL;
    endcase
  end

  always_ff @(posedge clk or posedge rstn_i) begin
    if (rstn_i) begin
      state_q       <= ST_FILL;
      in_x_q        <= '0;
      in_d_q        <= '0;
      in_y_q        <= '0;
      wr_slot_q     <= '0;
      out_row_q     <= '0;
      out_d_q       <= '0;
      mid_q         <= '0;
      pix_ready_o   <= 1'b0;
      image_start_o <= 1'b0;
      frame_done_o  <= 1'b0;
      image0_o      <= '0;
      image1_o      <= '0;
      image2_o      <= '0;
    end else begin
      state_q       <= state_d;
      in_x_q        <= in_x_d;
      in_d_q        <= in_d_d;
      in_y_q        <= in_y_d;
      wr_slot_q     <= wr_slot_d;
      out_row_q     <= out_row_d;
      out_d_q       <= out_d_d;
      mid_q         <= mid_d;
      pix_ready_o   <= (state_d == ST_FILL);
      image_start_o <= (state_d == ST_ISSUE);
      frame_done_o  <= frame_done_d;
      // Window is captured on entry to ISSUE so it is valid alongside image_start_o.
      if (state_d == ST_ISSUE) begin
        image0_o <= win0_c;
        image1_o <= win1_c;
        image2_o <= win2_c;
      end
    end
  end

`ifdef CONV_FEEDER_ERR_EN
  always_ff @(posedge clk or posedge rstn_i) begin
    if (rstn_i)
      err_o <= 1'b0;
    else if (conv_done_i && ((state_q != ST_WAIT) || image_start_o))
      err_o <= 1'b1;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_conv_row_feeder.sv
// Self-checking bench for conv_row_feeder with D=2, H=3, W=4 and pixel = y*16+d*8+x+1.
module tb_conv_row_feeder;

  localparam int unsigned D  = 2;
  localparam int unsigned H  = 3;
  localparam int unsigned W  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = DW * (W + 2);

  localparam int A_START = 0;
  localparam int A_FILL  = 1;
  localparam int A_DONE  = 2;

  typedef struct packed {
    logic [RW-1:0] r0;
    logic [RW-1:0] r1;
    logic [RW-1:0] r2;
  } win_t;

  typedef struct {
    int feed_rows;
    int done_delay;
    bit offer;
    int after;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rstn_i;
  logic signed [DW-1:0] pix_i;
  logic                 pix_valid_i;
  logic                 pix_ready_o;
  logic                 conv_done_i;
  logic [RW-1:0]        image0_o, image1_o, image2_o;
  logic                 image_start_o, frame_done_o, err_o;

  always #5 clk = ~clk;

  conv_row_feeder #(.D(D), .H(H), .W(W), .input_DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rstn_i        (rstn_i),
    .pix_i         (pix_i),
    .pix_valid_i   (pix_valid_i),
    .pix_ready_o   (pix_ready_o),
    .conv_done_i   (conv_done_i),
    .image0_o      (image0_o),
    .image1_o      (image1_o),
    .image2_o      (image2_o),
    .image_start_o (image_start_o),
    .frame_done_o  (frame_done_o),
    .err_o         (err_o)
  );

  int   checks = 0;
  int   errors = 0;
  int   hs_cnt = 0;
  int   start_cnt = 0;
  int   fd_cnt = 0;
  int   exp_starts = 0;
  int   exp_fd = 0;
  int   next_in_row = 0;
  win_t sb[$];
  win_t held;
  vec_t vecs[6];

  always @(posedge clk) begin
    if (!rstn_i && pix_valid_i && pix_ready_o) hs_cnt++;
    if (!rstn_i && image_start_o) start_cnt++;
    if (!rstn_i && frame_done_o) fd_cnt++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk_row(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [RW-1:0] exp_row(input int y, input int d);
    logic [RW-1:0] r;
    r = '0;
    if (y >= 0 && y < int'(H))
      for (int x = 0; x < int'(W); x++) r[(x+1)*DW +: DW] = DW'(y*16 + d*8 + x + 1);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input logic [DW-1:0] v);
    int n;
    n = 0;
    pix_i = v;
    pix_valid_i = 1'b1;
    while (!pix_ready_o && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk_bit("ready_timeout", pix_ready_o, 1'b1);
    tick();
  endtask

  // Expected windows are queued as soon as the row that unlocks them is driven.
  task automatic feed_row(input int y);
    win_t w;
    if (y >= 1) begin
      for (int d = 0; d < int'(D); d++) begin
        w.r0 = exp_row(y-2, d); w.r1 = exp_row(y-1, d); w.r2 = exp_row(y, d);
        sb.push_back(w);
      end
    end
    if (y == int'(H) - 1) begin
      for (int d = 0; d < int'(D); d++) begin
        w.r0 = exp_row(y-1, d); w.r1 = exp_row(y, d); w.r2 = exp_row(y+1, d);
        sb.push_back(w);
      end
    end
    for (int d = 0; d < int'(D); d++)
      for (int x = 0; x < int'(W); x++)
        send_pixel(DW'(y*16 + d*8 + x + 1));
  endtask

  task automatic take_window(input string name);
    win_t w;
    exp_starts++;
    chk_bit({name, "_start"}, image_start_o, 1'b1);
    chk_bit({name, "_ready"}, pix_ready_o, 1'b0);
    if (sb.size() == 0) begin
      chk_int({name, "_sb_empty"}, 0, 1);
    end else begin
      w = sb.pop_front();
      chk_row({name, "_img0"}, image0_o, w.r0);
      chk_row({name, "_img1"}, image1_o, w.r1);
      chk_row({name, "_img2"}, image2_o, w.r2);
    end
    held.r0 = image0_o; held.r1 = image1_o; held.r2 = image2_o;
  endtask

  task automatic respond(input string name, input int delay, input bit offer);
    int hs0;
    bit ok;
    hs0 = hs_cnt;
    ok = 1'b1;
    if (offer) begin
      pix_valid_i = 1'b1;
      pix_i = 8'sh55;
    end
    for (int k = 1; k < delay; k++) begin
      tick();
      if (pix_ready_o !== 1'b0 || image_start_o !== 1'b0 || image0_o !== held.r0 ||
          image1_o !== held.r1 || image2_o !== held.r2) ok = 1'b0;
    end
    pix_valid_i = 1'b0;
    tick();
    chk_bit({name, "_hold"}, ok, 1'b1);
    conv_done_i = 1'b1;
    tick();
    conv_done_i = 1'b0;
    if (offer) chk_int({name, "_no_consume"}, hs_cnt - hs0, 0);
  endtask

  task automatic run_frame(input string tag);
    int hs0;
    hs0 = hs_cnt;
    next_in_row = 0;
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < vecs[i].feed_rows; k++) begin
        feed_row(next_in_row);
        next_in_row++;
      end
      pix_valid_i = 1'b0;
      take_window($sformatf("%s_w%0d", tag, i));
      respond($sformatf("%s_w%0d", tag, i), vecs[i].done_delay, vecs[i].offer);
      if (vecs[i].after == A_FILL) begin
        chk_bit($sformatf("%s_w%0d_fill_ready", tag, i), pix_ready_o, 1'b1);
        chk_bit($sformatf("%s_w%0d_fill_nostart", tag, i), image_start_o, 1'b0);
      end else if (vecs[i].after == A_DONE) begin
        exp_fd++;
        chk_bit($sformatf("%s_w%0d_frame_done", tag, i), frame_done_o, 1'b1);
        chk_bit($sformatf("%s_w%0d_done_ready", tag, i), pix_ready_o, 1'b1);
      end
    end
    chk_int({tag, "_pixel_count"}, hs_cnt - hs0, int'(H*D*W));
    chk_int({tag, "_sb_drained"}, sb.size(), 0);
  endtask

  task automatic check_idle_outputs(input string name, input logic exp_ready);
    chk_bit({name, "_ready"}, pix_ready_o, exp_ready);
    chk_bit({name, "_start"}, image_start_o, 1'b0);
    chk_bit({name, "_fdone"}, frame_done_o, 1'b0);
    chk_bit({name, "_err"}, err_o, 1'b0);
    chk_row({name, "_img0"}, image0_o, '0);
    chk_row({name, "_img1"}, image1_o, '0);
    chk_row({name, "_img2"}, image2_o, '0);
  endtask

  initial begin
    logic exp_err;
`ifdef CONV_FEEDER_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    vecs[0] = '{feed_rows: 2, done_delay: 3,  offer: 1'b0, after: A_START};
    vecs[1] = '{feed_rows: 0, done_delay: 3,  offer: 1'b0, after: A_FILL};
    vecs[2] = '{feed_rows: 1, done_delay: 50, offer: 1'b1, after: A_START};
    vecs[3] = '{feed_rows: 0, done_delay: 1,  offer: 1'b0, after: A_START};
    vecs[4] = '{feed_rows: 0, done_delay: 2,  offer: 1'b0, after: A_START};
    vecs[5] = '{feed_rows: 0, done_delay: 4,  offer: 1'b0, after: A_DONE};

    rstn_i = 1'b1;
    pix_i = '0;
    pix_valid_i = 1'b0;
    conv_done_i = 1'b0;
    repeat (3) tick();
    check_idle_outputs("reset", 1'b0);
    rstn_i = 1'b0;
    tick();
    check_idle_outputs("post_reset", 1'b1);

    run_frame("f1");
    chk_bit("f1_err_clean", err_o, 1'b0);

    // Second frame aborted by reset while waiting on output row 1.
    feed_row(0);
    feed_row(1);
    pix_valid_i = 1'b0;
    take_window("f2_w0");
    respond("f2_w0", 3, 1'b0);
    take_window("f2_w1");
    respond("f2_w1", 3, 1'b0);
    feed_row(2);
    pix_valid_i = 1'b0;
    take_window("f2_w2");
    repeat (3) tick();
    rstn_i = 1'b1;
    tick();
    check_idle_outputs("mid_reset", 1'b0);
    rstn_i = 1'b0;
    sb.delete();
    tick();
    check_idle_outputs("mid_release", 1'b1);

    run_frame("f3");

    // Stray done while filling.
    conv_done_i = 1'b1;
    tick();
    conv_done_i = 1'b0;
    tick();
    chk_bit("err_set", err_o, exp_err);
    repeat (3) tick();
    chk_bit("err_sticky", err_o, exp_err);
    chk_bit("err_fill_ready", pix_ready_o, 1'b1);
    chk_bit("err_fill_nostart", image_start_o, 1'b0);
    rstn_i = 1'b1;
    tick();
    chk_bit("err_reset_clear", err_o, 1'b0);
    rstn_i = 1'b0;
    tick();

    chk_int("start_count", start_cnt, exp_starts);
    chk_int("frame_done_count", fd_cnt, exp_fd);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
